// File: rtl/iot_tx_serializer_pkg.sv
// Shared widths and FSM state type for the IoT byte-stream transmitter.
package iot_tx_pkg;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 128;
  localparam int unsigned BYTES_PER_WORD = 16;
  localparam int unsigned BIDX_W         = 4;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;
endpackage

// File: rtl/iot_tx_serializer_if.sv
// Word-stream handshake from the sensor/pattern producer into the serializer.
interface iot_tx_serializer_if;
  import iot_tx_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, s_last, s_valid, input s_ready);
  modport slave  (input s_data, s_last, s_valid, output s_ready);
endinterface

// File: rtl/iot_tx_serializer_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last,data} words.
module iot_tx_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
endmodule

// File: rtl/iot_tx_serializer.sv
// Buffers 128-bit words and issues them LSB byte first to IOTDF under busy back-pressure.
// Define IOT_TX_STATS_EN to add the word_cnt statistics port.
module iot_tx_serializer
  import iot_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  iot_tx_serializer_if.slave  s_if,
  input  logic                busy,
  output logic [BYTE_W-1:0]   iot_in,
  output logic                in_en,
  output logic                done
`ifdef IOT_TX_STATS_EN
  ,
  output logic [CNT_W-1:0]    word_cnt
`endif
);
  tx_state_t          state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [BIDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [BYTE_W-1:0]  iot_in_q, iot_in_d;
  logic               in_en_q, in_en_d;
  logic               done_q, done_d;
  logic               word_end;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [WORD_W:0]    fifo_rdata;

  iot_tx_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_if.s_valid),
    .wdata ({s_if.s_last, s_if.s_data}),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  // A finished non-last word always returns to IDLE; IDLE pops on the very
  // next edge, which keeps back-to-back words gapless.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    byte_idx_d = byte_idx_q;
    iot_in_d   = '0;
    in_en_d    = 1'b0;
    fifo_pop   = 1'b0;
    word_end   = 1'b0;
    if (!busy) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            word_d     = fifo_rdata[WORD_W-1:0];
            last_d     = fifo_rdata[WORD_W];
            iot_in_d   = fifo_rdata[BYTE_W-1:0];
            in_en_d    = 1'b1;
            byte_idx_d = BIDX_W'(1);
            state_d    = SEND;
          end
        end
        SEND: begin
          iot_in_d   = word_q[BYTE_W*byte_idx_q +: BYTE_W];
          in_en_d    = 1'b1;
          byte_idx_d = byte_idx_q + BIDX_W'(1);
          if (byte_idx_q == BIDX_W'(BYTES_PER_WORD - 1)) begin
            word_end = 1'b1;
            state_d  = last_q ? DONE : IDLE;
          end
        end
        default: ;
      endcase
    end
    done_d = done_q || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      last_q     <= 1'b0;
      byte_idx_q <= '0;
      iot_in_q   <= '0;
      in_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      last_q     <= last_d;
      byte_idx_q <= byte_idx_d;
      iot_in_q   <= iot_in_d;
      in_en_q    <= in_en_d;
      done_q     <= done_d;
    end
  end

`ifdef IOT_TX_STATS_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb word_cnt_d = word_cnt_q + CNT_W'(word_end);

  always_ff @(posedge clk) begin
    if (!rst) word_cnt_q <= '0;
    else      word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`endif

  assign s_if.s_ready = !fifo_full;
  assign iot_in       = iot_in_q;
  assign in_en        = in_en_q;
  assign done         = done_q;
endmodule

// File: tb/tb_iot_tx_serializer.sv
// Self-checking bench for iot_tx_serializer: directed scenarios plus randomized busy/traffic
// checked cycle by cycle against a queue-based reference model.
module tb_iot_tx_serializer;
  localparam int unsigned DEPTH = 4;
  localparam logic [127:0] W_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy = 1'b0;
  logic [7:0]  iot_in;
  logic        in_en;
  logic        done;
`ifdef IOT_TX_STATS_EN
  logic [15:0] word_cnt;
`endif

  iot_tx_serializer_if bus ();

  iot_tx_serializer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_if   (bus.slave),
    .busy   (busy),
    .iot_in (iot_in),
    .in_en  (in_en),
    .done   (done)
`ifdef IOT_TX_STATS_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words waiting, bytes left in the current word, frame finished.
  logic [128:0] mq[$];
  logic [127:0] cur_word;
  logic         cur_last;
  int           rem;
  bit           mdone, mvalid;
  logic         e_en, e_done, e_ready;
  logic [7:0]   e_byte;
  logic [15:0]  e_cnt;
  bit           rdy_before;

  initial begin
    rem = 0; mdone = 0; mvalid = 0; cur_word = '0; cur_last = 0;
    e_en = 0; e_done = 0; e_ready = 1; e_byte = 0; e_cnt = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      rem = 0; mdone = 0; mvalid = 1;
      e_en = 0; e_byte = 0; e_done = 0; e_cnt = 0; e_ready = 1;
    end else begin
      rdy_before = (mq.size() < DEPTH);
      e_done = e_done | mdone;
      e_en = 0; e_byte = 0;
      if (!busy && !mdone) begin
        if (rem != 0) begin
          e_en = 1; e_byte = cur_word[8*(16-rem) +: 8]; rem--;
        end else if (mq.size() != 0) begin
          {cur_last, cur_word} = mq.pop_front();
          e_en = 1; e_byte = cur_word[7:0]; rem = 15;
        end
        if (e_en && rem == 0) begin
          e_cnt++;
          if (cur_last) mdone = 1;
        end
      end
      if (bus.s_valid && rdy_before) mq.push_back({bus.s_last, bus.s_data});
      e_ready = (mq.size() < DEPTH);
    end
  end

  logic [7:0] seen[$];

  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      check("in_en", in_en, e_en);
      check("iot_in", iot_in, e_byte);
      check("done", done, e_done);
      check("s_ready", bus.s_ready, e_ready);
`ifdef IOT_TX_STATS_EN
      check("word_cnt", word_cnt, e_cnt);
`endif
    end
    if (in_en) seen.push_back(iot_in);
  end

  bit tog = 0;

  task automatic step();
    @(negedge clk);
    if (tog) busy = ~busy;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    seen.delete();
  endtask

  task automatic push_word(input logic [127:0] d, input logic l);
    int unsigned n;
    logic took;
    n = 0;
    bus.s_data = d; bus.s_last = l; bus.s_valid = 1'b1;
    do begin
      took = bus.s_ready;
      step();
      n++;
    end while (!took && n < 300);
    bus.s_valid = 1'b0;
    if (!took) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input int unsigned nbytes, input int unsigned budget);
    for (int unsigned i = 0; i < budget && seen.size() < nbytes; i++) step();
    check("byte_count", seen.size(), nbytes);
  endtask

  logic [7:0]   exp_stream[$];
  logic [127:0] w;
  int unsigned  gap;

  initial begin
    bus.s_data = '0; bus.s_last = 1'b0; bus.s_valid = 1'b0;
    step();
    do_reset();
    check("rst_in_en", in_en, 1'b0);
    check("rst_iot_in", iot_in, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_ready", bus.s_ready, 1'b1);

    // 1: single word, no back-pressure
    push_word(W_SEQ, 1'b0);
    wait_bytes(16, 40);
    for (int i = 0; i < 16 && i < seen.size(); i++) check("t1_byte", seen[i], i);

    // 2: stall for 3 cycles after byte 05
    do_reset();
    push_word(W_SEQ, 1'b0);
    for (int i = 0; i < 40 && !(in_en && iot_in == 8'h05); i++) step();
    check("t2_saw_05", {in_en, iot_in}, {1'b1, 8'h05});
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_en", in_en, 1'b0);
    end
    busy = 1'b0;
    wait_bytes(16, 40);
    for (int i = 0; i < 16 && i < seen.size(); i++) check("t2_byte", seen[i], i);

    // 3: two-word frame
    do_reset();
    push_word(W_SEQ, 1'b0);
    push_word(~W_SEQ, 1'b1);
    for (int i = 0; i < 60 && !done; i++) step();
    check("t3_done", done, 1'b1);
    check("t3_bytes", seen.size(), 32);
    if (seen.size() == 32) check("t3_byte16", seen[16], 8'hFF);
`ifdef IOT_TX_STATS_EN
    check("t3_word_cnt", word_cnt, 16'd2);
`endif

    // 4: fill FIFO while stalled
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push_word({120'(i), 8'(8'h10 + i)}, 1'b0);
    check("t4_full", bus.s_ready, 1'b0);
    bus.s_data = {120'd4, 8'h14}; bus.s_last = 1'b0; bus.s_valid = 1'b1;
    busy = 1'b0;
    step();
    check("t4_ready_after_pop", bus.s_ready, 1'b1);
    step();
    bus.s_valid = 1'b0;
    wait_bytes(80, 150);
    for (int i = 0; i < 5; i++) if (seen.size() == 80) check("t4_b0", seen[16*i], 8'h10 + i);

    // 5: reset while byte 07 is issued
    do_reset();
    push_word(W_SEQ, 1'b0);
    for (int i = 0; i < 40 && !(in_en && iot_in == 8'h06); i++) step();
    rst = 1'b0;
    step();
    check("t5_in_en", in_en, 1'b0);
    check("t5_ready", bus.s_ready, 1'b1);
    check("t5_done", done, 1'b0);
    rst = 1'b1;
    seen.delete();
    push_word(W_SEQ, 1'b0);
    wait_bytes(16, 40);
    if (seen.size() != 0) check("t5_restart", seen[0], 8'h00);

    // 6: randomized traffic, busy toggling every cycle
    do_reset();
    exp_stream.delete();
    tog = 1;
    for (int i = 0; i < 96; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < 16; b++) exp_stream.push_back(w[8*b +: 8]);
      push_word(w, (i == 95));
      gap = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gap; g++) step();
    end
    for (int i = 0; i < 6000 && !done; i++) step();
    tog = 0;
    busy = 1'b0;
    check("t6_done", done, 1'b1);
    check("t6_count", seen.size(), exp_stream.size());
    for (int i = 0; i < exp_stream.size() && i < seen.size(); i++) check("t6_byte", seen[i], exp_stream[i]);
`ifdef IOT_TX_STATS_EN
    check("t6_word_cnt", word_cnt, 16'd96);
`endif

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
